// File: rtl/rfphoenix_issue_stage_pkg.sv
// Shared types for the rfPhoenix issue stage: decode bus, fetch buffer and skid entry.
package rfPhoenixPkg;

    localparam int NREGS_DEFAULT = 64;
    localparam int RW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [RW_DEFAULT-1:0] regspec_t;

    typedef struct packed {
        logic [7:0]  opcode;
        regspec_t    Ra;
        regspec_t    Rb;
        regspec_t    Rc;
        regspec_t    Rt;
        logic        rfwr;
        logic [15:0] imm;
    } decode_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } instruction_fetchbuf_t;

    typedef struct packed {
        decode_bus_t           dec;
        instruction_fetchbuf_t ifb;
    } skid_entry_t;

endpackage

// File: rtl/rfphoenix_issue_stage_scoreboard.sv
// Register busy scoreboard with RAW/WAW hazard lookup for the head instruction.
// RFPHOENIX_ISSUE_WB_BYPASS_EN lets a same-cycle writeback unblock the lookup.
module rfphoenix_scoreboard
    import rfPhoenixPkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_v,
    input  logic [RW-1:0]    set_rt,
    input  logic             wb_v,
    input  logic [RW-1:0]    wb_rt,
    input  logic [RW-1:0]    chk_ra,
    input  logic [RW-1:0]    chk_rb,
    input  logic [RW-1:0]    chk_rc,
    input  logic [RW-1:0]    chk_rt,
    input  logic             chk_rfwr,
    output logic             hazard,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] set_mask, clr_mask, look;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_v && set_rt != '0) set_mask[set_rt] = 1'b1;
        if (wb_v && wb_rt != '0)   clr_mask[wb_rt]  = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

`ifdef RFPHOENIX_ISSUE_WB_BYPASS_EN
    assign look = busy_q & ~clr_mask;
`else
    assign look = busy_q;
`endif

    // r0 is never set, so its lookup always reads 0.
    assign hazard = look[chk_ra] | look[chk_rb] | look[chk_rc] | (chk_rfwr & look[chk_rt]);
    assign busy   = busy_q;

endmodule

// File: rtl/rfphoenix_issue_stage.sv
// Issue stage: pops the instruction FIFO into a 2-entry skid buffer and issues
// hazard-free instructions. Optional macro: RFPHOENIX_ISSUE_WB_BYPASS_EN.
module rfphoenix_issue_stage
    import rfPhoenixPkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_v,
    input  decode_bus_t           fifo_dec,
    input  instruction_fetchbuf_t fifo_ifb,
    output logic                  fifo_rd,
    input  logic                  flush,
    input  logic                  wb_v,
    input  logic [RW-1:0]         wb_Rt,
    input  logic                  iss_rdy,
    output logic                  iss_v,
    output decode_bus_t           iss_dec,
    output instruction_fetchbuf_t iss_ifb,
    output logic                  stall,
    output logic [NREGS-1:0]      busy
);

    skid_entry_t           skid_q [2];
    skid_entry_t           skid_d [2];
    skid_entry_t           incoming;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic                  iss_v_q, stall_q;
    decode_bus_t           iss_dec_q;
    instruction_fetchbuf_t iss_ifb_q;
    logic                  hazard, push, pop;
    logic [2:0]            committed;

    rfphoenix_scoreboard #(.NREGS(NREGS), .RW(RW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_v    (pop & skid_q[0].dec.rfwr),
        .set_rt   (skid_q[0].dec.Rt),
        .wb_v     (wb_v),
        .wb_rt    (wb_Rt),
        .chk_ra   (skid_q[0].dec.Ra),
        .chk_rb   (skid_q[0].dec.Rb),
        .chk_rc   (skid_q[0].dec.Rc),
        .chk_rt   (skid_q[0].dec.Rt),
        .chk_rfwr (skid_q[0].dec.rfwr),
        .hazard   (hazard),
        .busy     (busy)
    );

    // A valid without a matching read in flight is ignored; flush beats push and pop.
    assign push      = inflight_q & fifo_v & ~flush;
    assign pop       = (occ_q != 2'd0) & ~hazard & (~iss_v_q | iss_rdy) & ~flush;
    assign committed = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    // Held low during reset so the FIFO is not drained into a pipeline being cleared.
    assign fifo_rd   = rst & ~fifo_empty & ~flush & (committed < 3'd2);

    always_comb begin
        skid_d       = skid_q;
        occ_d        = occ_q;
        incoming.dec = fifo_dec;
        incoming.ifb = fifo_ifb;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            if (pop) skid_d[0] = skid_q[1];
            unique case ({push, pop})
                2'b10: begin
                    skid_d[occ_q[0]] = incoming;
                    occ_d            = occ_q + 2'd1;
                end
                2'b01: occ_d = occ_q - 2'd1;
                2'b11: skid_d[occ_q[1]] = incoming;
                default: ;
            endcase
        end
    end

    // NOTE: skid payload is qualified by occ_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            iss_v_q    <= 1'b0;
            iss_dec_q  <= '0;
            iss_ifb_q  <= '0;
            stall_q    <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd;
            stall_q    <= (occ_q != 2'd0) & hazard;
            if (flush) begin
                iss_v_q <= 1'b0;
            end else if (pop) begin
                iss_v_q   <= 1'b1;
                iss_dec_q <= skid_q[0].dec;
                iss_ifb_q <= skid_q[0].ifb;
            end else if (iss_rdy) begin
                iss_v_q <= 1'b0;
            end
        end
    end

    assign iss_v   = iss_v_q;
    assign iss_dec = iss_dec_q;
    assign iss_ifb = iss_ifb_q;
    assign stall   = stall_q;

endmodule

// File: tb/tb_rfphoenix_issue_stage.sv
// Self-checking bench for rfphoenix_issue_stage with a behavioural upstream FIFO.
module tb_rfphoenix_issue_stage;
    import rfPhoenixPkg::*;

`ifdef RFPHOENIX_ISSUE_WB_BYPASS_EN
    localparam int RAW_ISS_K = 9;
`else
    localparam int RAW_ISS_K = 10;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  fifo_empty, fifo_v, fifo_rd, flush, wb_v, iss_rdy;
    decode_bus_t           fifo_dec, iss_dec;
    instruction_fetchbuf_t fifo_ifb, iss_ifb;
    logic [5:0]            wb_Rt;
    logic                  iss_v, stall;
    logic [63:0]           busy;

    rfphoenix_issue_stage dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_v(fifo_v),
        .fifo_dec(fifo_dec), .fifo_ifb(fifo_ifb), .fifo_rd(fifo_rd),
        .flush(flush), .wb_v(wb_v), .wb_Rt(wb_Rt), .iss_rdy(iss_rdy),
        .iss_v(iss_v), .iss_dec(iss_dec), .iss_ifb(iss_ifb),
        .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    skid_entry_t q[$];
    logic [31:0] log_pc[$];
    int          log_cyc[$];

    logic                  s_rd, s_iv, s_rdy, s_stall;
    decode_bus_t           s_dec;
    instruction_fetchbuf_t s_ifb;
    logic [63:0]           s_busy;

    typedef struct {
        skid_entry_t ent;
        logic [63:0] exp_set;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic skid_entry_t mk(input logic [31:0] pc, input logic [5:0] ra, input logic [5:0] rb,
                                       input logic [5:0] rc, input logic [5:0] rt, input logic wr);
        skid_entry_t e;
        e          = '0;
        e.dec.Ra   = ra;
        e.dec.Rb   = rb;
        e.dec.Rc   = rc;
        e.dec.Rt   = rt;
        e.dec.rfwr = wr;
        e.dec.imm  = pc[15:0];
        e.ifb.pc   = pc;
        e.ifb.insn = pc ^ 32'hA5A5_0000;
        return e;
    endfunction

    task automatic enq(input skid_entry_t e);
        q.push_back(e);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample at negedge, then advance the FIFO model after the edge.
    task automatic cyc();
        @(negedge clk);
        s_rd = fifo_rd; s_iv = iss_v; s_rdy = iss_rdy; s_stall = stall;
        s_dec = iss_dec; s_ifb = iss_ifb; s_busy = busy;
        if (s_iv && s_rdy) begin
            log_pc.push_back(s_ifb.pc);
            log_cyc.push_back(cyc_cnt);
        end
        @(posedge clk);
        #1;
        if (s_rd && q.size() > 0) begin
            skid_entry_t e;
            e        = q.pop_front();
            fifo_v   = 1'b1;
            fifo_dec = e.dec;
            fifo_ifb = e.ifb;
        end else begin
            fifo_v = 1'b0;
        end
        fifo_empty = (q.size() == 0);
        cyc_cnt++;
    endtask

    task automatic wb_one(input logic [5:0] r);
        wb_v = 1'b1; wb_Rt = r;
        cyc();
        wb_v = 1'b0; wb_Rt = '0;
    endtask

    initial begin
        skid_entry_t a, b;
        logic [63:0] exp_mask;
        int start;

        tbl[0] = '{mk(32'h100, 6'd1, 6'd2, 6'd0, 6'd10, 1'b1), 64'h400};
        tbl[1] = '{mk(32'h104, 6'd3, 6'd0, 6'd0, 6'd11, 1'b1), 64'h800};
        tbl[2] = '{mk(32'h108, 6'd0, 6'd0, 6'd0, 6'd12, 1'b1), 64'h1000};
        tbl[3] = '{mk(32'h10C, 6'd1, 6'd0, 6'd0, 6'd10, 1'b0), 64'h0};
        tbl[4] = '{mk(32'h110, 6'd2, 6'd0, 6'd0, 6'd14, 1'b1), 64'h4000};
        tbl[5] = '{mk(32'h114, 6'd3, 6'd0, 6'd0, 6'd0,  1'b1), 64'h0};
        tbl[6] = '{mk(32'h118, 6'd0, 6'd0, 6'd0, 6'd11, 1'b0), 64'h0};
        tbl[7] = '{mk(32'h11C, 6'd4, 6'd0, 6'd0, 6'd17, 1'b1), 64'h20000};

        rst = 1'b0; fifo_empty = 1'b1; fifo_v = 1'b0; fifo_dec = '0; fifo_ifb = '0;
        flush = 1'b0; wb_v = 1'b0; wb_Rt = '0; iss_rdy = 1'b1;
        #2;
        check("rst_iss_v", iss_v, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Single instruction; a same-cycle writeback to r3 must lose to the set.
        enq(mk(32'h40, 6'd1, 6'd2, 6'd0, 6'd3, 1'b1));
        wb_v = 1'b1; wb_Rt = 6'd3;
        cyc(); check("t1_rd_c0", s_rd, 1); check("t1_iv_c0", s_iv, 0);
        cyc(); check("t1_rd_c1", s_rd, 0);
        cyc(); check("t1_iv_c2", s_iv, 0);
        wb_v = 1'b0;
        cyc(); check("t1_iv_c3", s_iv, 1); check("t1_pc_c3", s_ifb.pc, 32'h40);
        check("t1_busy_c3", s_busy, 64'h8);
        cyc(); check("t1_iv_c4", s_iv, 0);
        wb_one(6'd3);
        cyc(); check("t1_busy_clr", s_busy, 0);

        // Back-to-back independent instructions from the table.
        log_pc.delete(); log_cyc.delete();
        exp_mask = '0;
        for (int i = 0; i < 8; i++) begin
            enq(tbl[i].ent);
            exp_mask |= tbl[i].exp_set;
        end
        start = cyc_cnt;
        for (int k = 0; k < 14; k++) cyc();
        check("t2_count", log_pc.size(), 8);
        if (log_cyc.size() > 0) check("t2_first_cyc", log_cyc[0] - start, 3);
        for (int i = 0; i < 8 && i < log_pc.size(); i++) begin
            check($sformatf("t2_pc%0d", i), log_pc[i], tbl[i].ent.ifb.pc);
            check($sformatf("t2_cyc%0d", i), log_cyc[i] - log_cyc[0], i);
        end
        check("t2_busy", s_busy, exp_mask);
        wb_one(6'd10); wb_one(6'd11); wb_one(6'd12); wb_one(6'd14); wb_one(6'd0); wb_one(6'd17);
        cyc(); check("t2_busy_clr", s_busy, 0);

        // RAW: B reads r5 written by A.
        log_pc.delete(); log_cyc.delete();
        a = mk(32'h200, 6'd0, 6'd0, 6'd0, 6'd5, 1'b1);
        b = mk(32'h204, 6'd5, 6'd0, 6'd0, 6'd6, 1'b1);
        enq(a); enq(b);
        for (int k = 0; k < 14; k++) begin
            if (k == 8) begin wb_v = 1'b1; wb_Rt = 6'd5; end
            else        begin wb_v = 1'b0; wb_Rt = '0; end
            cyc();
            if (k == 3) check("t3_a_iss", s_ifb.pc, 32'h200);
            if (k == 4) check("t3_busy5", s_busy, 64'h20);
            if (k == 5) check("t3_stall", s_stall, 1);
            if (k == 7) check("t3_b_held", s_iv, 0);
            if (k == RAW_ISS_K - 1) check("t3_b_not_yet", s_iv, 0);
            if (k == RAW_ISS_K) begin
                check("t3_b_iv", s_iv, 1);
                check("t3_b_pc", s_ifb.pc, 32'h204);
                check("t3_busy6", s_busy, 64'h40);
            end
            if (k == 12) check("t3_stall_off", s_stall, 0);
        end
        wb_one(6'd6);

        // Backpressure with four queued instructions.
        log_pc.delete(); log_cyc.delete();
        iss_rdy = 1'b0;
        for (int i = 0; i < 4; i++) enq(mk(32'h300 + 32'(4 * i), 6'd0, 6'd0, 6'd0, 6'd0, 1'b0));
        for (int k = 0; k < 20; k++) begin
            if (k == 9) iss_rdy = 1'b1;
            cyc();
            if (k >= 3 && k <= 8) check($sformatf("t4_rd%0d", k), s_rd, 0);
            if (k >= 4 && k <= 8) begin
                check($sformatf("t4_iv%0d", k), s_iv, 1);
                check($sformatf("t4_pc%0d", k), s_ifb.pc, 32'h300);
                check($sformatf("t4_ins%0d", k), s_ifb.insn, 32'h300 ^ 32'hA5A5_0000);
            end
        end
        check("t4_count", log_pc.size(), 4);
        for (int i = 0; i < 4 && i < log_pc.size(); i++)
            check($sformatf("t4_ord%0d", i), log_pc[i], 32'h300 + 32'(4 * i));

        // Flush with a read returning and one buffered entry.
        log_pc.delete(); log_cyc.delete();
        enq(mk(32'h400, 6'd0, 6'd0, 6'd0, 6'd7, 1'b1));
        enq(mk(32'h404, 6'd0, 6'd0, 6'd0, 6'd8, 1'b1));
        enq(mk(32'h408, 6'd0, 6'd0, 6'd0, 6'd9, 1'b1));
        enq(mk(32'h40C, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0));
        for (int k = 0; k < 12; k++) begin
            flush = (k == 3);
            if (k == 4) begin
                fifo_v = 1'b1; fifo_ifb.pc = 32'hDEAD; fifo_dec = '0;
            end
            cyc();
            if (k == 3) begin
                check("t5_rd_flush", s_rd, 0);
                check("t5_fifo_v", fifo_v, 0);
            end
            if (k == 4) check("t5_iv_after", s_iv, 0);
            if (k == 5) check("t5_busy", s_busy, 64'h80);
        end
        check("t5_count", log_pc.size(), 2);
        if (log_pc.size() == 2) begin
            check("t5_first", log_pc[0], 32'h400);
            check("t5_second", log_pc[1], 32'h40C);
        end
        wb_one(6'd7);
        cyc(); check("t5_busy_clr", s_busy, 0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) enq(mk(32'h500 + 32'(4 * i), 6'd0, 6'd0, 6'd0, 6'(20 + i), 1'b1));
        for (int k = 0; k < 4; k++) cyc();
        check("t6_pre_busy", busy, 64'h30_0000);
        check("t6_pre_iv", iss_v, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_iv", iss_v, 0);
        check("t6_dec", iss_dec, 0);
        check("t6_ifb", iss_ifb, 0);
        check("t6_stall", stall, 0);
        check("t6_busy", busy, 0);
        check("t6_rd", fifo_rd, 0);
        @(posedge clk); @(posedge clk); #1;
        q.delete(); fifo_empty = 1'b1; fifo_v = 1'b0;
        rst = 1'b1;
        cyc(); check("t6_post_iv", s_iv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rfphoenix_issue_stage.md
Name: rfphoenix_issue_stage

Overview:
- Downstream consumer of the instruction FIFO (distributed-RAM sync FIFO, read latency 1, data_valid flag).
- Pops decoded instructions, buffers them in a 2-entry skid buffer, and checks a register scoreboard for RAW/WAW hazards.
- Issues one instruction per cycle to the execute stage over a valid/ready handshake.
- Scoreboard bits are set at issue and cleared by writeback.

Parameters:
- NREGS, 64, architectural registers tracked by the scoreboard; register 0 is never busy.
- RW, $clog2(NREGS), register-specifier width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_v  in  1  FIFO data_valid; dout is valid this cycle.
- fifo_dec  in  $bits(decode_bus_t)  FIFO decode-bus output.
- fifo_ifb  in  $bits(instruction_fetchbuf_t)  FIFO fetch-buffer output.
- fifo_rd  out  1  FIFO read enable.
- flush  in  1  pipeline flush; discards all buffered and in-flight instructions.
- wb_v  in  1  writeback valid.
- wb_Rt  in  RW  writeback target register.
- iss_rdy  in  1  execute stage accepts iss_* this cycle.
- iss_v  out  1  issue valid.
- iss_dec  out  $bits(decode_bus_t)  issued decode bus.
- iss_ifb  out  $bits(instruction_fetchbuf_t)  issued fetch buffer.
- stall  out  1  head instruction blocked by a hazard.
- busy  out  NREGS  scoreboard image, for debug.

Behaviour:
- Reset (rst=0, async): fifo_rd=0, iss_v=0, iss_dec=0, iss_ifb=0, stall=0, busy=0. Skid occupancy 0, in-flight flag 0.
- decode_bus_t fields used: Ra, Rb, Rc, Rt (RW bits), rfwr (1 bit).
- FIFO read:
  - fifo_rd = !fifo_empty & !flush & (occ + inflight - pop) < 2.
  - occ = skid entries 0..2; inflight = fifo_rd registered; pop = head moved to the issue register this cycle.
  - A read asserted in cycle N returns data in N+1 with fifo_v=1. It is written to the skid tail at the N+1 edge.
  - fifo_v=1 while inflight=0 is ignored (protects against a spurious valid).
- Skid buffer:
  - 2-entry FIFO ordered head/tail.
  - Simultaneous push and pop allowed; occupancy never exceeds 2.
- Hazard on the head entry: busy[Ra] | busy[Rb] | busy[Rc] | (rfwr & busy[Rt]). Index 0 always reads 0.
- Issue register:
  - pop = occ>0 & !hazard & (!iss_v | iss_rdy).
  - On pop: iss_dec/iss_ifb load the head, iss_v=1.
  - On iss_rdy & iss_v & !pop: iss_v=0.
  - iss_* hold stable while iss_v & !iss_rdy.
- Latency, empty pipeline: fifo_rd cycle 0, fifo_v cycle 1, head valid cycle 2, iss_v cycle 3. Sustained throughput is 1 instruction/cycle when there are no hazards.
- stall = occ>0 & hazard (registered, one cycle behind).
- Scoreboard update:
  - On pop with rfwr & Rt!=0: set busy[Rt].
  - On wb_v & wb_Rt!=0: clear busy[wb_Rt].
  - Same register set and cleared in the same cycle: set wins.
- Flush:
  - Synchronous. Clears occ, inflight and iss_v next edge; data returning on fifo_v the cycle after flush is dropped.
  - fifo_rd=0 during flush.
  - Scoreboard is NOT cleared; in-flight writebacks still clear their bits.
- Flush has priority over pop and push in the same cycle.

Optional Feature:
- Macro: RFPHOENIX_ISSUE_WB_BYPASS_EN.
- Defined: the hazard check uses busy & ~(wb_v ? onehot(wb_Rt) : 0). An instruction waiting on a register issues in the same cycle as that register's writeback.
- Undefined: the hazard check uses registered busy only, so issue occurs one cycle after writeback.

Decomposition:
- rfPhoenixPkg holds decode_bus_t, instruction_fetchbuf_t, regspec_t (RW bits) and NREGS default.
- Sub-module rfphoenix_scoreboard holds the busy vector, set/clear logic and the hazard lookup, with the bypass macro inside.
- Skid buffer and issue register stay in the top module.

Test Plan:
- Single instruction: FIFO holds Ra=1,Rb=2,Rt=3,rfwr=1 with iss_rdy=1. Expect fifo_rd at cycle 0 and iss_v=1 at cycle 3. Expect busy[3]=1 at cycle 3 and busy otherwise 0.
- Back-to-back: 8 independent instructions, iss_rdy=1. Expect iss_v high 8 consecutive cycles in order, with no FIFO read beyond skid capacity.
- RAW stall: insn A writes r5, insn B reads r5. Expect B held and stall=1 until wb_v=1,wb_Rt=5. Without the macro, B issues one cycle after writeback; with RFPHOENIX_ISSUE_WB_BYPASS_EN, B issues the same cycle.
- Backpressure: iss_rdy=0 for 5 cycles with 4 queued instructions. Expect iss_* stable, occ=2, fifo_rd=0. After release, all 4 issue in order with no loss or duplication.
- Flush: assert flush the cycle fifo_v=1 with occ=2. Next cycle expect iss_v=0, occ=0 and returning data dropped; busy bits set earlier are unchanged and clear on subsequent writebacks.
- Async reset: drop rst mid-stream. Expect all outputs and busy at 0 immediately, before the next clk edge.
